// File: rtl/multi_digit_display_pkg.sv
// multi_digit_display_pkg: blank constant, hex-to-segment table and scan-state type.
package multi_digit_display_pkg;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic [2:0] {DIG_0, DIG_1, DIG_2, DIG_3, DIG_4, DIG_5, DIG_6, DIG_7} scan_state_e;
  function automatic int state_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/SegmentDecoder.sv
// SegmentDecoder: one hex digit to active-low 7-segment pattern.
module SegmentDecoder
  import multi_digit_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TBL[digit_i];
endmodule

// File: rtl/multi_digit_display.sv
// multi_digit_display: shadowed hex display with leading-zero blanking, blink and optional scan.
module multi_digit_display
  import multi_digit_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN       = 0,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blink_phase
);
  localparam int BW = state_w(BLINK_DIV);
  localparam int SW = state_w(SCAN_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam scan_state_e LAST_STATE = scan_state_e'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_RST = SCAN != 0 ? NUM_DIGITS'(1) : '1;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic                    loaded_q;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    phase_q, phase_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  scan_state_e             state_q, state_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  always_comb begin
    bcnt_d  = bcnt_q == BLINK_LAST ? '0 : bcnt_q + 1'b1;
    phase_d = bcnt_q == BLINK_LAST ? ~phase_q : phase_q;
    scnt_d  = scnt_q == SCAN_LAST ? '0 : scnt_q + 1'b1;
    state_d = scnt_q != SCAN_LAST ? state_q :
              state_q == LAST_STATE ? DIG_0 : scan_state_e'(state_q + 1'b1);
    sel_d   = SCAN != 0 ? NUM_DIGITS'(1) << state_q : '1;
  end
  // Blank priority: not loaded, scan-inactive, blink, leading zero, then decoded digit.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [6:0] seg;
    logic       lz, active;
    SegmentDecoder u_dec (.digit_i(shadow_q[4*i+:4]), .seg_o(seg));
    assign lz = (i != 0) && lz_blank && shadow_q[4*NUM_DIGITS-1:4*i] == '0;
    assign active = (SCAN == 0) || (state_q == scan_state_e'(i));
    assign hex_d[7*i+:7] = !loaded_q || !active || (phase_q && blink_en[i]) || lz ? BLANK : seg;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      loaded_q <= 1'b0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      scnt_q   <= '0;
      state_q  <= DIG_0;
      hex_q    <= '1;
      sel_q    <= SEL_RST;
    end else begin
      if (load) begin
        shadow_q <= value;
        loaded_q <= 1'b1;
      end
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      scnt_q  <= scnt_d;
      state_q <= state_d;
      hex_q   <= hex_d;
      sel_q   <= sel_d;
    end
  end
  assign HEX         = hex_q;
  assign digit_sel   = sel_q;
  assign blink_phase = phase_q;
endmodule

// File: tb/tb_multi_digit_display.sv
// tb_multi_digit_display: static and scan instances checked every cycle against an arithmetic model.
module tb_multi_digit_display;
  logic        clk = 0, reset, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  blink_en;
  logic [27:0] hex0, hex1;
  logic [3:0]  sel0, sel1;
  logic        ph0, ph1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  multi_digit_display #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN(0), .SCAN_DIV(2)) d0 (
    .clk(clk), .reset(reset), .value(value), .load(load), .lz_blank(lz_blank),
    .blink_en(blink_en), .HEX(hex0), .digit_sel(sel0), .blink_phase(ph0));
  multi_digit_display #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN(1), .SCAN_DIV(2)) d1 (
    .clk(clk), .reset(reset), .value(value), .load(load), .lz_blank(lz_blank),
    .blink_en(blink_en), .HEX(hex1), .digit_sel(sel1), .blink_phase(ph1));
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  // Display after an edge, given k clean edges since reset before it: phase = (k/4)%2, scan index = (k/2)%4.
  function automatic logic [27:0] disp(bit scan, int k, logic ld, logic [15:0] sh, logic lzb, logic [3:0] bl);
    logic [27:0] r;
    logic [3:0] d;
    bit lead, b;
    lead = 1;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      d = sh[4*i+:4];
      lead = lead && d == 0 && i != 0;
      b = !ld || (scan && i != (k / 2) % 4) || (((k / 4) % 2) == 1 && bl[i]) || (lzb && lead);
      r[7*i+:7] = b ? 7'h7F : tbl[d];
    end
    return r;
  endfunction
  int k;
  bit valid = 0, m_ld;
  logic [15:0] m_sh;
  logic [27:0] e_hex0, e_hex1;
  logic [3:0]  e_sel1;
  logic        e_ph;
  always @(posedge clk) begin
    if (reset) begin
      valid = 1; k = 0; m_ld = 0; m_sh = '0;
      e_hex0 = '1; e_hex1 = '1; e_sel1 = 4'b0001; e_ph = 0;
    end else if (valid) begin
      e_hex0 = disp(0, k, m_ld, m_sh, lz_blank, blink_en);
      e_hex1 = disp(1, k, m_ld, m_sh, lz_blank, blink_en);
      e_sel1 = 4'b0001 << ((k / 2) % 4);
      if (load) begin m_sh = value; m_ld = 1; end
      k++;
      e_ph = ((k / 4) % 2) == 1;
    end
  end
  always @(negedge clk) begin
    if (valid) begin
      chk("hex_static", hex0, e_hex0);
      chk("hex_scan", hex1, e_hex1);
      chk("sel_static", sel0, 4'hF);
      chk("sel_scan", sel1, e_sel1);
      chk("phase_static", ph0, e_ph);
      chk("phase_scan", ph1, e_ph);
    end
  end
  task automatic pulse_load(logic [15:0] v);
    value = v; load = 1;
    @(negedge clk);
    load = 0;
    @(negedge clk);
  endtask
  initial begin
    reset = 1; load = 0; value = '0; lz_blank = 0; blink_en = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("lit_reset_hex", hex0, 28'hFFFFFFF);
    chk("lit_reset_sel_scan", sel1, 4'b0001);
    repeat (3) @(negedge clk);
    chk("lit_sel_scan_k3", sel1, 4'b0010);
    @(negedge clk);
    chk("lit_phase_k4", ph0, 1'b1);
    repeat (6) @(negedge clk);
    chk("lit_phase_k10", ph0, 1'b0);
    chk("lit_idle_hex", hex0, 28'hFFFFFFF);
    pulse_load(16'h12AF);
    chk("lit_12AF", hex0, {7'h79, 7'h24, 7'h08, 7'h0E});
    value = 16'h5555;
    repeat (3) @(negedge clk);
    chk("lit_12AF_held", hex0, {7'h79, 7'h24, 7'h08, 7'h0E});
    lz_blank = 1;
    pulse_load(16'h0070);
    chk("lit_lz_0070", hex0, {7'h7F, 7'h7F, 7'h78, 7'h40});
    pulse_load(16'h0000);
    chk("lit_lz_0000", hex0, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    pulse_load(16'h0804);
    repeat (3) @(negedge clk);
    lz_blank = 0;
    pulse_load(16'h12AF);
    blink_en = 4'b0001;
    repeat (16) @(negedge clk);
    blink_en = 4'b1010;
    lz_blank = 1;
    pulse_load(16'h00C3);
    repeat (12) @(negedge clk);
    reset = 1; load = 1; value = 16'hFFFF;
    @(negedge clk);
    reset = 0; load = 0; blink_en = '0; lz_blank = 0;
    chk("lit_rst_load_hex", hex0, 28'hFFFFFFF);
    repeat (5) @(negedge clk);
    chk("lit_rst_load_held", hex0, 28'hFFFFFFF);
    pulse_load(16'h9E6B);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_digit_display.md
MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of hex digits driven (legal 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25_000_000, clock cycles per blink half-period (legal >=2).
REQ-003 SHALL have parameter SCAN, default 0, output mode: 0 = static (all digits driven), 1 = time-multiplexed scan.
REQ-004 SHALL have parameter SCAN_DIV, default 50_000, clock cycles each digit is active in scan mode (legal >=1).
REQ-005 SHALL have port clk  input  1  system clock; one clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i]; digit 0 is the least significant.
REQ-008 SHALL have port load  input  1  when high, value is captured into the shadow register.
REQ-009 SHALL have port lz_blank  input  1  leading-zero suppression enable.
REQ-010 SHALL have port blink_en  input  NUM_DIGITS  per-digit blink enable.
REQ-011 SHALL have port HEX  output  7*NUM_DIGITS  registered segments, digit i = HEX[7i+6:7i], active-low, bit 0 = a ... bit 6 = g.
REQ-012 SHALL have port digit_sel  output  NUM_DIGITS  registered, active-high, digit-enable strobe.
REQ-013 SHALL have port blink_phase  output  1  registered; 1 = blinking digits are currently dark.

Function
REQ-014 Load: the shadow register SHALL capture value on the edge where load=1; the "loaded" flag SHALL set on that edge.
REQ-015 Latency: HEX SHALL reflect a load on the second rising edge after the load edge (shadow, then output register).
REQ-016 Until the first load after reset, every digit SHALL be blank (7'h7F).
REQ-017 Encoding SHALL be 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E (hex, 7-bit).
REQ-018 Leading zeros: when lz_blank=1, the contiguous run of 0 digits starting at digit NUM_DIGITS-1 SHALL be blank; digit 0 SHALL never be blanked by this rule; interior zeros SHALL display.
REQ-019 lz_blank and blink_en SHALL be applied combinationally ahead of the output register, so a change appears on HEX one edge later.
REQ-020 Blink counter SHALL count 0..BLINK_DIV-1 and wrap; on the wrap edge blink_phase SHALL toggle.
REQ-021 While blink_phase=1, each digit i with blink_en[i]=1 SHALL be blank; the counter SHALL run regardless of load or blink_en.
REQ-022 Static mode (SCAN=0): digit_sel SHALL be all ones and all HEX fields SHALL carry their digits.
REQ-023 Scan mode (SCAN=1): a scan FSM with states DIG_0..DIG_{NUM_DIGITS-1} SHALL advance every SCAN_DIV cycles and wrap from the last state to DIG_0.
REQ-024 In scan mode, digit_sel SHALL be one-hot at the active index; HEX fields of inactive digits SHALL be 7'h7F.
REQ-025 Blank priority SHALL be: not loaded > scan-inactive > blink > leading-zero > decoded digit.
REQ-026 Counter widths SHALL be $clog2 of their divisors; there SHALL be no overflow beyond the wrap value.

Reset
REQ-027 Reset SHALL clear the shadow register to 0, the loaded flag, the blink counter, blink_phase and the scan counter, and set the scan state to DIG_0.
REQ-028 After reset, HEX SHALL be all 7'h7F; digit_sel SHALL be all ones (SCAN=0) or 1 (SCAN=1); blink_phase SHALL be 0.
REQ-029 Reset SHALL take priority over a simultaneous load; reset mid-blink or mid-scan SHALL restart both counters from 0.

Structure
REQ-030 The shared package SHALL hold the BLANK constant 7'h7F, the 16-entry encoding table, and the scan-state width function.
REQ-031 The design SHALL instantiate the team's existing combinational SegmentDecoder once per digit via generate; no other sub-module.

Verification (NUM_DIGITS=4, BLINK_DIV=4, SCAN_DIV=2 unless noted)
REQ-032 Reset then idle 10 cycles -> HEX = 28'hFFFFFFF, blink_phase toggles every 4 cycles.
REQ-033 load with value=16'h12AF -> HEX = {79,24,08,0E} two edges later and held after load drops.
REQ-034 value=16'h0070, lz_blank=1 -> digits 3,2 = 7F, digit 1 = 78, digit 0 = 40; value=16'h0000 -> only digit 0 shows 40.
REQ-035 blink_en=4'b0001 on a loaded value -> digit 0 alternates decoded/7F every 4 cycles; other digits steady.
REQ-036 SCAN=1 -> digit_sel sequence 0001,0010,0100,1000,0001 at 2 cycles each; inactive fields = 7F.
REQ-037 reset and load asserted on the same edge -> shadow stays 0, HEX stays all blank.
